counter_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one loadable binary up counter (din/load/count datapath) among N requesters. It grants one requester, loads that requester's start value into the counter, and waits for the counter to reach terminal count (all ones). It then pulses done to that requester and moves on. The counter is external: this block drives its load/din and observes its count.

---
 rtl/counter_rr_scheduler_if.sv | 24 ++
 rtl/counter_rr_scheduler.sv | 109 ++++++++++
 tb/tb_counter_rr_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_rr_scheduler_if.sv
// Handshake bundle between the round-robin scheduler (master) and its requesters plus shared counter (slave).
interface counter_rr_scheduler_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] start_val;
  logic [W-1:0]   cnt_q;
  logic           cnt_load;
  logic [W-1:0]   cnt_din;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;

  modport master (
    input  req, start_val, cnt_q,
    output cnt_load, cnt_din, gnt, done, busy
  );

  modport slave (
    output req, start_val, cnt_q,
    input  cnt_load, cnt_din, gnt, done, busy
  );
endinterface

// File: rtl/counter_rr_scheduler.sv
// Round-robin share of one external loadable up counter; done fires (2^W+1-start) edges after grant.
// No backpressure: requests seen only in IDLE, dropping req while granted aborts without done.
module counter_rr_scheduler #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_rr_scheduler_if.master  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic            cnt_load_q, cnt_load_d;
  logic [W-1:0]    cnt_din_q, cnt_din_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   idx_nxt;

  // First requester at or after ptr, wrapping modulo N
  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!pick_vld && bus.req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign idx_nxt = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    cnt_load_d = 1'b0;
    cnt_din_d  = cnt_din_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          cnt_din_d       = bus.start_val[pick_idx*W +: W];
          cnt_load_d      = 1'b1;
          state_d         = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Abort wins over terminal count in the same cycle
        if (!bus.req[idx_q]) begin
          gnt_d   = '0;
          ptr_d   = idx_nxt;
          state_d = IDLE;
        end else if (bus.cnt_q == {W{1'b1}}) begin
          gnt_d         = '0;
          done_d[idx_q] = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        ptr_d   = idx_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      cnt_load_q <= 1'b0;
      cnt_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      cnt_load_q <= cnt_load_d;
      cnt_din_q  <= cnt_din_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.cnt_load = cnt_load_q;
  assign bus.cnt_din  = cnt_din_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler with a behavioural load/increment counter.
module tb_counter_rr_scheduler;
  localparam int N = 4;
  localparam int W = 4;

  logic clk;
  logic rst;
  logic [W-1:0] cnt;
  int n_chk;
  int n_err;

  counter_rr_scheduler_if #(.N(N), .W(W)) bus ();

  counter_rr_scheduler #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: load on cnt_load, else increment with wrap
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (bus.cnt_load) cnt <= bus.cnt_din;
    else cnt <= cnt + 1'b1;
  end
  assign bus.cnt_q = cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int i, input int v);
    bus.start_val[i*W +: W] = W'(v);
  endtask

  // Waits for a grant, then counts edges from the granting edge until done.
  task automatic measure(input string tag, input int exp_idx, input int exp_lat, output int gap);
    int lat;
    int loads;
    logic bad;
    logic [N-1:0] g;
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[exp_idx] = 1'b1;
    gap = 0;
    while (bus.gnt == '0 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_oh));
    lat   = 0;
    loads = bus.cnt_load ? 1 : 0;
    bad   = 1'b0;
    while (bus.done == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
      g = bus.gnt;
      if ((g & (g - 1'b1)) != '0) bad = 1'b1;
      if ((bus.done & g) != '0) bad = 1'b1;
      if (bus.cnt_load) loads++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_done"}, 32'(bus.done), 32'(exp_oh));
    chk({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_loads"}, 32'(loads), 32'd1);
    chk({tag, "_onehot"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int gap;
    int k;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.start_val = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_load", 32'(bus.cnt_load), 32'd0);
    chk("rst_din", 32'(bus.cnt_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single requester, start 13 -> done 4 edges after grant
    set_start(0, 13);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("t1_din", 32'(bus.cnt_din), 32'd13);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    measure("t1", 0, 4, gap);
    bus.req = '0;
    @(negedge clk);
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    chk("t1_busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("t1_idle_gnt", 32'(bus.gnt), 32'd0);

    // 2: all request from reset, start 14 -> order 0,1,2,3,0
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_start(i, 14);
    bus.req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    measure("t2_r0", 0, 3, gap);
    chk("t2_gap0", 32'(gap), 32'd1);
    measure("t2_r1", 1, 3, gap);
    chk("t2_gap1", 32'(gap), 32'd2);
    measure("t2_r2", 2, 3, gap);
    chk("t2_gap2", 32'(gap), 32'd2);
    measure("t2_r3", 3, 3, gap);
    chk("t2_gap3", 32'(gap), 32'd2);
    measure("t2_r0b", 0, 3, gap);
    chk("t2_gap4", 32'(gap), 32'd2);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // 3a: start 15 -> done 2 edges after grant (ptr now 1)
    set_start(1, 15);
    bus.req = 4'b0010;
    measure("t3a", 1, 2, gap);

    // 4: requester 2 granted then aborted at cnt 5; requester 3 follows
    set_start(2, 2);
    set_start(3, 0);
    bus.req = 4'b1100;
    k = 0;
    while (bus.gnt == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t4_gnt", 32'(bus.gnt), 32'h4);
    k = 0;
    while (cnt != 4'd5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t4_cnt5", 32'(cnt), 32'd5);
    bus.req = 4'b1000;
    @(negedge clk);
    chk("t4_abort_gnt", 32'(bus.gnt), 32'd0);
    chk("t4_abort_done", 32'(bus.done), 32'd0);
    chk("t4_abort_busy", 32'(bus.busy), 32'd0);

    // 3b: requester 3 with start 0 -> done 17 edges after grant
    measure("t3b", 3, 17, gap);
    chk("t3b_gap", 32'(gap), 32'd1);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // 6: req drops exactly while cnt_q is terminal -> abort, no done
    set_start(0, 13);
    bus.req = 4'b0001;
    k = 0;
    while (bus.gnt == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t6_gnt", 32'(bus.gnt), 32'h1);
    k = 0;
    while (cnt != 4'd15 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t6_cnt15", 32'(cnt), 32'd15);
    bus.req = '0;
    @(negedge clk);
    chk("t6_done", 32'(bus.done), 32'd0);
    chk("t6_gnt_clr", 32'(bus.gnt), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("t6_done_late", 32'(bus.done), 32'd0);

    // 5: async reset mid-RUN, then ptr back at 0 (ptr was 1 before reset)
    set_start(1, 0);
    bus.req = 4'b0010;
    k = 0;
    while (bus.gnt == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_gnt", 32'(bus.gnt), 32'h2);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_async_busy", 32'(bus.busy), 32'd0);
    chk("t5_async_load", 32'(bus.cnt_load), 32'd0);
    chk("t5_async_done", 32'(bus.done), 32'd0);
    bus.req = 4'b0011;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (bus.gnt == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_ptr0_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
